compute_vex_gen: RTL
====================

Name: compute_vex_gen

Overview:
Parametrised successor to the exercise-value generator for the American-put lattice engine. It walks the final-step nodes of the binomial lattice in price space using a fixed-point multiplicative recurrence. For each node it computes the early-exercise payoff and streams one value per cycle to the lattice value RAM write port. New relative to the previous generation: put/call mode, runtime node count, parametrised width/precision/address base, busy/done status, and overflow saturation.

Parameters:
DATA_W, 32, width of all price/payoff words (unsigned fixed point)
FRAC_W, 24, fractional bits; 1.0 = 2^FRAC_W
ADDR_W, 13, RAM address width
ADDR_BASE, 0, address written for node 0

Ports:
clk  in  1  rising-edge clock
nrst  in  1  synchronous active-low reset
start  in  1  one-cycle request; accepted only when idle
mode  in  1  0 = put payoff, 1 = call payoff; latched on start
num_nodes  in  ADDR_W+1  nodes to emit; latched on start
base_price  in  DATA_W  price/S of node 0 (lowest node, d^N); latched
ratio  in  DATA_W  u/d per node step; latched
K_over_S  in  DATA_W  strike/S; latched
v_ex  out  DATA_W  payoff for current node
wraddr  out  ADDR_W  RAM write address
wren  out  1  write strobe
busy  out  1  high while a run is in progress
done  out  1  one-cycle pulse after the last write

Behaviour:
- Reset: one clock and one reset, nrst is synchronous active-low. While nrst=0 at a rising edge, v_ex=0, wraddr=0, wren=0, busy=0, done=0, FSM goes to IDLE, internal price/index registers clear. A reset mid-run aborts the run immediately: no further wren and no done.
- FSM states: IDLE, RUN, FIN.
- IDLE -> RUN on edge E0 where start=1. At E0: latch mode, K_over_S, ratio, and n = min(num_nodes, 2^ADDR_W); load price=base_price; idx=0; busy=1.
- IDLE -> FIN instead if the clamped n=0. In this case there are no writes, and busy stays 0.
- RUN: at each edge E(k+1), k = 0..n-1, the registered outputs take these values:
  - wren=1
  - wraddr = (ADDR_BASE + k) mod 2^ADDR_W
  - v_ex = payoff(price_k)
  - price advances to price_(k+1) = sat((price_k * ratio) >> FRAC_W); the full 2*DATA_W product is truncated, not rounded.
  - sat() clamps to 2^DATA_W-1 if any bits above DATA_W remain.
- First write is therefore registered one edge after start is sampled. Throughput is 1 node/clock with no bubbles.
- Payoff:
  - put: K_over_S - P if P < K_over_S, else 0.
  - call: P - K_over_S if P > K_over_S, else 0.
  - Computed unsigned; the result never underflows.
- After the write for k=n-1, go to FIN. At that edge busy still reads 1 with the last wren.
- FIN, one cycle: at edge E(n+1), wren=0, busy=0, done=1. Next edge: done=0, FSM to IDLE.
- start while busy or in FIN is ignored, with no effect on latched operands.
- Input changes after E0 do not affect the run.
- Outside RUN, wren=0. v_ex and wraddr hold their last values and are don't-care to the RAM.
- Address wrap: wraddr wraps modulo 2^ADDR_W when ADDR_BASE + k overflows.
- Back-to-back runs: the earliest accepted start is the cycle in which done=1 is visible, because the FSM is in IDLE on that edge's next cycle. The minimum start-to-start spacing is n+2 cycles.

Test Plan:
1. FRAC_W=24, put, base_price=0x00800000 (0.5), ratio=0x02000000 (2.0), K_over_S=0x02000000, num_nodes=4 -> wren for 4 cycles starting one edge after start; addr 0,1,2,3; v_ex=0x01800000, 0x01000000, 0, 0; done pulses one cycle after the last write; busy covers the writes exactly.
2. Same operands with mode=1 (call) -> v_ex=0, 0, 0, 0x02000000.
3. Saturation, call: base_price=0x40000000 (64.0), ratio=0x10000000 (16.0), K=0x02000000, num_nodes=3 -> v_ex=0x3E000000, 0xFDFFFFFF, 0xFDFFFFFF (price clamped to 0xFFFFFFFF).
4. num_nodes=0 -> no wren; done=1 on the edge after start; busy never rises. Then num_nodes=8192 with ADDR_BASE=8190 -> 8192 writes, wraddr 8190, 8191, 0, 1, ... wrapping, followed by one done.
5. start pulsed again mid-run (with different num_nodes) -> ignored; write count and addresses unchanged. A start issued during the done cycle's following idle cycle -> new run begins normally.
6. nrst=0 asserted for one cycle at write k=2 of an 8-node run -> outputs all 0 on that edge, no further wren, no done. A fresh start afterward produces a full correct run from addr 0.

Source files
------------

// File: rtl/compute_vex_gen.sv
// Walks the final-step lattice nodes with a fixed-point price recurrence and streams each early-exercise payoff to the value RAM.
// First write is one cycle after start, then one node per cycle with no bubbles; no backpressure (the RAM port always accepts).
module compute_vex_gen #(
    parameter int DATA_W    = 32,
    parameter int FRAC_W    = 24,
    parameter int ADDR_W    = 13,
    parameter int ADDR_BASE = 0
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W:0]   num_nodes,
    input  logic [DATA_W-1:0] base_price,
    input  logic [DATA_W-1:0] ratio,
    input  logic [DATA_W-1:0] K_over_S,
    output logic [DATA_W-1:0] v_ex,
    output logic [ADDR_W-1:0] wraddr,
    output logic              wren,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [ADDR_W:0]   MAX_N  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(ADDR_BASE);

    state_t              state;
    logic                mode_q;
    logic [DATA_W-1:0]   k_q;
    logic [DATA_W-1:0]   ratio_q;
    logic [ADDR_W:0]     n_q;
    logic [DATA_W-1:0]   price;
    logic [ADDR_W-1:0]   idx;

    logic [ADDR_W:0]     n_clamp;
    logic [2*DATA_W-1:0] prod;
    logic [2*DATA_W-1:0] shifted;
    logic [DATA_W-1:0]   price_nxt;
    logic [DATA_W-1:0]   payoff;
    logic                last;

    always_comb begin
        n_clamp = (num_nodes > MAX_N) ? MAX_N : num_nodes;

        // Full-width product, truncated after the shift; any surviving high bits saturate.
        prod      = (2*DATA_W)'(price) * (2*DATA_W)'(ratio_q);
        shifted   = prod >> FRAC_W;
        price_nxt = (|shifted[2*DATA_W-1:DATA_W]) ? {DATA_W{1'b1}} : shifted[DATA_W-1:0];

        payoff = '0;
        if (mode_q) begin
            if (price > k_q)
                payoff = price - k_q;
        end else begin
            if (price < k_q)
                payoff = k_q - price;
        end

        last = ({1'b0, idx} == (n_q - (ADDR_W+1)'(1)));
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state   <= IDLE;
            mode_q  <= 1'b0;
            k_q     <= '0;
            ratio_q <= '0;
            n_q     <= '0;
            price   <= '0;
            idx     <= '0;
            v_ex    <= '0;
            wraddr  <= '0;
            wren    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    wren <= 1'b0;
                    done <= 1'b0;
                    if (start) begin
                        mode_q  <= mode;
                        k_q     <= K_over_S;
                        ratio_q <= ratio;
                        n_q     <= n_clamp;
                        price   <= base_price;
                        idx     <= '0;
                        // An empty run still reports completion, but never looks busy.
                        if (n_clamp == '0) begin
                            state <= FIN;
                        end else begin
                            busy  <= 1'b1;
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    wren   <= 1'b1;
                    wraddr <= BASE_A + idx;
                    v_ex   <= payoff;
                    price  <= price_nxt;
                    idx    <= idx + 1'b1;
                    if (last)
                        state <= FIN;
                end
                FIN: begin
                    wren  <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    wren  <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
